htonl_serial: RTL

Bit-serial host-to-network byte-order converter for the bit-serial datapath; it is the transmit-side counterpart of the network-to-host converter. It sits between a host-order bit stream and the network-facing serial path. It captures one 32-bit word MSB-first while replaying the previous word byte-swapped, also MSB-first, giving exactly one word of latency. It also checks bit-counter continuity and reports when its output carries a valid converted word.

---
 rtl/htonl_serial.sv | 121 ++++++++++++
 1 files changed

// File: rtl/htonl_serial.sv
// Bit-serial host-to-network byte-order converter.
// Captures one 32-bit word MSB-first while replaying the previous word
// byte-swapped, MSB-first, giving exactly one word of latency.
// Also checks bit-counter continuity and flags when out carries a full word.
module htonl_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bclk,
  input  logic [4:0] counter,
  input  logic       in,
  output logic       out,
  output logic       word_valid,
  output logic       seq_err
);

  localparam int unsigned WordW = 32;
  localparam int unsigned ByteW = 8;
  localparam int unsigned CntW  = 5;
  localparam int unsigned FillW = 6;

  localparam logic [FillW-1:0] FillFull = FillW'(WordW);
  localparam logic [FillW-1:0] FillOne  = FillW'(1);
  localparam logic [CntW-1:0]  LastIdx  = CntW'(WordW - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [CntW-1:0]  CntZero  = CntW'(0);

  // Reverse byte order of a word; bit order inside each byte is kept.
  function automatic logic [WordW-1:0] byteswap(input logic [WordW-1:0] x);
    byteswap = {x[ByteW-1:0], x[2*ByteW-1:ByteW],
                x[3*ByteW-1:2*ByteW], x[4*ByteW-1:3*ByteW]};
  endfunction

  logic             bclk_prev_q;
  logic [WordW-1:0] cap_q,  cap_d;
  logic [WordW-1:0] play_q, play_d;
  logic [CntW-1:0]  exp_q,  exp_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             seen_q, seen_d;
  logic             out_q,  out_d;
  logic             wv_q,   wv_d;
  logic             err_q,  err_d;

  logic rise_c;
  logic fall_c;
  logic mismatch_c;

  // Bit-clock edge detection in the clk domain; at most one edge per clk.
  assign rise_c     = !bclk_prev_q &&  bclk;
  assign fall_c     =  bclk_prev_q && !bclk;
  // The first rise after reset has no reference counter, so it is never flagged.
  assign mismatch_c = seen_q && (counter != exp_q);

  // Next-state logic: record on rise, play on fall.
  always_comb begin
    cap_d  = cap_q;
    play_d = play_q;
    exp_d  = exp_q;
    fill_d = fill_q;
    seen_d = seen_q;
    out_d  = out_q;
    wv_d   = wv_q;
    err_d  = 1'b0;

    if (rise_c) begin
      // Bank load uses the pre-shift capture, i.e. the just-completed word.
      if (counter == CntZero) begin
        play_d = byteswap(cap_q);
      end
      cap_d  = {cap_q[WordW-2:0], in};
      exp_d  = counter + CntOne;
      seen_d = 1'b1;

      if (mismatch_c) begin
        err_d  = 1'b1;
        fill_d = FillOne;
        wv_d   = 1'b0;
      end else begin
        if (fill_q < FillFull) begin
          fill_d = fill_q + FillOne;
        end
        if (counter == CntZero) begin
          wv_d = (fill_q == FillFull);
        end
      end
    end

    if (fall_c) begin
      out_d = play_q[LastIdx - counter];
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_prev_q <= 1'b0;
      cap_q       <= '0;
      play_q      <= '0;
      exp_q       <= '0;
      fill_q      <= '0;
      seen_q      <= 1'b0;
      out_q       <= 1'b0;
      wv_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bclk_prev_q <= bclk;
      cap_q       <= cap_d;
      play_q      <= play_d;
      exp_q       <= exp_d;
      fill_q      <= fill_d;
      seen_q      <= seen_d;
      out_q       <= out_d;
      wv_q        <= wv_d;
      err_q       <= err_d;
    end
  end

  assign out        = out_q;
  assign word_valid = wv_q;
  assign seq_err    = err_q;

endmodule
